// File: rtl/sevenseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-slot blanking,
// frame snapshot, hex decode and leading-zero suppression.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic [3:0] dp_en,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic INV = (ACTIVE_LOW != 0);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } phase_e;

  phase_e phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] slot_q, slot_d;

  logic [3:0][3:0] dig_q;
  logic [3:0] dpen_q;
  logic lz_q;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d;

  logic capture;
  logic [3:0] cur;
  logic [3:0] dark;
  logic [6:0] seg_raw;
  logic on;

  assign capture = enable && (slot_q == 2'd0) && (cnt_q == '0);
  assign frame_tick = capture && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      slot_q  <= 2'd0;
      phase_q <= ST_BLANK;
      dig_q   <= '0;
      dpen_q  <= 4'd0;
      lz_q    <= 1'b0;
      an_q    <= {4{INV}};
      seg_q   <= {7{INV}};
      dp_q    <= INV;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      if (capture) begin
        dig_q  <= {digit3, digit2, digit1, digit0};
        dpen_q <= dp_en;
        lz_q   <= blank_lz;
      end
      an_q  <= an_d ^ {4{INV}};
      seg_q <= seg_d ^ {7{INV}};
      dp_q  <= dp_d ^ INV;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (!enable) begin
      cnt_d  = '0;
      slot_d = 2'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      slot_d = slot_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    phase_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_DRIVE;
  end

  // Zero suppression chains from the leftmost digit inward.
  always_comb begin
    dark    = 4'd0;
    dark[3] = lz_q && (dig_q[3] == 4'd0);
    dark[2] = dark[3] && (dig_q[2] == 4'd0);
    dark[1] = dark[2] && (dig_q[1] == 4'd0);
  end

  assign cur = dig_q[slot_q];

  always_comb begin
    seg_raw = 7'h00;
    unique case (cur)
      4'h0: seg_raw = 7'h3F;
      4'h1: seg_raw = 7'h06;
      4'h2: seg_raw = 7'h5B;
      4'h3: seg_raw = 7'h4F;
      4'h4: seg_raw = 7'h66;
      4'h5: seg_raw = 7'h6D;
      4'h6: seg_raw = 7'h7D;
      4'h7: seg_raw = 7'h07;
      4'h8: seg_raw = 7'h7F;
      4'h9: seg_raw = 7'h6F;
      4'hA: seg_raw = 7'h77;
      4'hB: seg_raw = 7'h7C;
      4'hC: seg_raw = 7'h39;
      4'hD: seg_raw = 7'h5E;
      4'hE: seg_raw = 7'h79;
      4'hF: seg_raw = 7'h71;
    endcase
  end

  always_comb begin
    on    = enable && (phase_q == ST_DRIVE) && !dark[slot_q];
    an_d  = 4'd0;
    seg_d = 7'd0;
    dp_d  = 1'b0;
    if (on) begin
      an_d  = 4'd1 << slot_q;
      seg_d = seg_raw;
      dp_d  = dpen_q[slot_q];
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
